bp_nonsynth_commit_trace_arbiter: RTL and testbench
===================================================

// Module: bp_nonsynth_commit_trace_arbiter
// PURPOSE
//  Shares one commit-trace sink (file writer / trace FIFO) among num_req_p cores.
//  Each core presents retired-instruction records on a v/yumi channel.
//  Round-robin arbitration picks one record per cycle, stamps it with the hart id
//  and a per-hart retire tag, and holds it in a one-entry output register.
//  The sink drains that register over a v/ready channel. Sits between the
//  per-core commit monitors and the single trace writer in the testbench top.
// PARAMETERS
//  num_req_p      4   number of requesting cores (>=1)
//  vaddr_width_p  39  commit PC width
//  instr_width_p  32  instruction width
//  dpath_width_p  64  rd write-data width
//  itag_width_p   30  per-hart retire-tag width; wraps modulo 2^itag_width_p
//  hid_width_lp   `BSG_SAFE_CLOG2(num_req_p)  (localparam)
// PORTS
//  clk_i             in   1                    clock, posedge
//  reset_n_i         in   1                    async reset, active-low
//  en_i              in   1                    1=grant allowed; 0=no new grants, output still drains
//  req_v_i           in   num_req_p            per-core record valid
//  req_pc_i          in   num_req_p*vaddr_width_p  per-core commit PC (core i at slice i)
//  req_instr_i       in   num_req_p*instr_width_p  per-core instruction
//  req_rd_w_v_i      in   num_req_p            per-core rd write valid
//  req_rd_addr_i     in   num_req_p*5          per-core rd index
//  req_rd_data_i     in   num_req_p*dpath_width_p  per-core rd data
//  req_yumi_o        out  num_req_p            one-hot (or 0) record consumed this cycle
//  trace_v_o         out  1                    output register valid
//  trace_hartid_o    out  hid_width_lp         source core index
//  trace_pc_o        out  vaddr_width_p        recorded PC
//  trace_instr_o     out  instr_width_p        recorded instruction
//  trace_itag_o      out  itag_width_p         per-hart retire tag of this record
//  trace_rd_w_v_o    out  1                    rd write valid
//  trace_rd_addr_o   out  5                    rd index
//  trace_rd_data_o   out  dpath_width_p        rd data
//  trace_ready_i     in   1                    sink accepts when trace_v_o & trace_ready_i
// BEHAVIOUR
//  - Reset (reset_n_i=0, async): trace_v_o=0, all trace_*_o data=0, rr pointer=0,
//    all itag counters=0. req_yumi_o=0 while in reset. In-flight record discarded.
//  - load = ~trace_v_o | trace_ready_i  (register empty or draining this cycle).
//  - grant = load & en_i & |req_v_i. Winner = first i with req_v_i[i], scanning
//    ptr, ptr+1, ... mod num_req_p. req_yumi_o[winner]=grant; combinational, same cycle.
//  - On grant, posedge: output regs <= winner's fields, hartid=winner,
//    itag=itag_r[winner]; trace_v_o<=1; itag_r[winner]++ (wraps 2^itag_width_p-1 -> 0);
//    ptr <= (winner+1) mod num_req_p.
//  - On load & ~grant: trace_v_o<=0. Data regs hold.
//  - On ~load: everything holds. Output fields stable while trace_v_o & ~trace_ready_i.
//  - Latency: req accepted at cycle N appears on trace_*_o at cycle N+1.
//  - Throughput: 1 record/cycle when trace_ready_i held 1.
//  - Simultaneous drain+grant in one cycle: new record replaces old, trace_v_o stays 1.
//  - en_i=0: pending record still drains. itag and ptr frozen.
//  - Requesters must hold req_* stable until yumi.
//  - Ptr advances only on grant. With all cores requesting, each core is served
//    once per num_req_p grants (no starvation).
//  - num_req_p=1: ptr fixed 0, hartid_o=0.
// TESTING
//  1 reset: assert reset_n_i mid-stream with trace_v_o=1 -> trace_v_o=0 immediately,
//    next grant to core0 with itag=0.
//  2 fairness: num_req_p=4, all req_v_i=1, ready=1 for 8 cycles ->
//    hartid sequence 0,1,2,3,0,1,2,3; itags 0,0,0,0,1,1,1,1.
//  3 backpressure: ready=0 for 5 cycles with record pc=0x80000000 ->
//    fields stable, req_yumi_o=0, no itag change; ready=1 -> next record the following cycle.
//  4 wrap: itag_width_p=2, core2 sends 5 records -> itags 0,1,2,3,0.
//  5 en_i: en_i=0 with requests pending and one record valid -> that record drains,
//    then trace_v_o=0, yumi=0 until en_i=1.
//  6 sparse: only core3 requests, ptr=0 -> core3 granted in the same cycle,
//    ptr becomes 0 (3+1 mod 4).

Source files
------------

// File: rtl/bp_nonsynth_commit_trace_arbiter.sv
// bp_nonsynth_commit_trace_arbiter
//   Shares one commit-trace sink among num_req_p cores. Each cycle a
//   round-robin arbiter picks one retired-instruction record from the
//   requesting cores, stamps it with the hart id and that hart's retire tag,
//   and loads it into a one-entry output register drained by the sink.
//
// Ports
//   clk_i            clock, rising edge
//   reset_n_i        asynchronous reset, active low
//   en_i             1 = new grants allowed; 0 = no grants, output still drains
//   req_v_i          per-core record valid
//   req_pc_i         per-core commit PC, core i at slice i
//   req_instr_i      per-core instruction
//   req_rd_w_v_i     per-core rd write valid
//   req_rd_addr_i    per-core rd index
//   req_rd_data_i    per-core rd write data
//   req_yumi_o       one-hot (or zero) record consumed this cycle
//   trace_v_o        output register valid
//   trace_hartid_o   source core of the held record
//   trace_pc_o       held PC
//   trace_instr_o    held instruction
//   trace_itag_o     per-hart retire tag of the held record
//   trace_rd_w_v_o   held rd write valid
//   trace_rd_addr_o  held rd index
//   trace_rd_data_o  held rd data
//   trace_ready_i    sink accepts when trace_v_o & trace_ready_i

module bp_nonsynth_commit_trace_arbiter #(
  parameter int num_req_p     = 4,
  parameter int vaddr_width_p = 39,
  parameter int instr_width_p = 32,
  parameter int dpath_width_p = 64,
  parameter int itag_width_p  = 30,
  localparam int hid_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic                               en_i,
  input  logic [num_req_p-1:0]               req_v_i,
  input  logic [num_req_p*vaddr_width_p-1:0] req_pc_i,
  input  logic [num_req_p*instr_width_p-1:0] req_instr_i,
  input  logic [num_req_p-1:0]               req_rd_w_v_i,
  input  logic [num_req_p*5-1:0]             req_rd_addr_i,
  input  logic [num_req_p*dpath_width_p-1:0] req_rd_data_i,
  output logic [num_req_p-1:0]               req_yumi_o,
  output logic                               trace_v_o,
  output logic [hid_width_lp-1:0]            trace_hartid_o,
  output logic [vaddr_width_p-1:0]           trace_pc_o,
  output logic [instr_width_p-1:0]           trace_instr_o,
  output logic [itag_width_p-1:0]            trace_itag_o,
  output logic                               trace_rd_w_v_o,
  output logic [4:0]                         trace_rd_addr_o,
  output logic [dpath_width_p-1:0]           trace_rd_data_o,
  input  logic                               trace_ready_i
);

  localparam int unsigned nreq_lp = num_req_p;

  // Per-core views of the packed request buses
  logic [vaddr_width_p-1:0] pc_a    [num_req_p];
  logic [instr_width_p-1:0] instr_a [num_req_p];
  logic [4:0]               addr_a  [num_req_p];
  logic [dpath_width_p-1:0] data_a  [num_req_p];

  for (genvar g = 0; g < num_req_p; g++) begin : g_unpack
    assign pc_a[g]    = req_pc_i[g*vaddr_width_p +: vaddr_width_p];
    assign instr_a[g] = req_instr_i[g*instr_width_p +: instr_width_p];
    assign addr_a[g]  = req_rd_addr_i[g*5 +: 5];
    assign data_a[g]  = req_rd_data_i[g*dpath_width_p +: dpath_width_p];
  end

  logic [hid_width_lp-1:0]  ptr_q, ptr_d;
  logic [itag_width_p-1:0]  itag_q [num_req_p];
  logic [itag_width_p-1:0]  itag_d [num_req_p];

  logic                     trace_v_q, trace_v_d;
  logic [hid_width_lp-1:0]  trace_hartid_q, trace_hartid_d;
  logic [vaddr_width_p-1:0] trace_pc_q, trace_pc_d;
  logic [instr_width_p-1:0] trace_instr_q, trace_instr_d;
  logic [itag_width_p-1:0]  trace_itag_q, trace_itag_d;
  logic                     trace_rd_w_v_q, trace_rd_w_v_d;
  logic [4:0]               trace_rd_addr_q, trace_rd_addr_d;
  logic [dpath_width_p-1:0] trace_rd_data_q, trace_rd_data_d;

  logic                     load;
  logic                     grant;
  logic                     found;
  logic [hid_width_lp-1:0]  winner;
  logic [hid_width_lp-1:0]  idx_h;
  int unsigned              idx;

  // Round-robin scan starting at ptr_q; the first requester found wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    idx_h  = '0;
    for (int unsigned k = 0; k < nreq_lp; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= nreq_lp) idx = idx - nreq_lp;
      idx_h = hid_width_lp'(idx);
      if (!found && req_v_i[idx_h]) begin
        found  = 1'b1;
        winner = idx_h;
      end
    end
  end

  // Reset is folded into grant so no record is acknowledged while in reset.
  assign load  = ~trace_v_q | trace_ready_i;
  assign grant = reset_n_i & load & en_i & found;

  always_comb begin
    req_yumi_o = '0;
    if (grant) req_yumi_o[winner] = 1'b1;
  end

  always_comb begin
    ptr_d           = ptr_q;
    itag_d          = itag_q;
    trace_v_d       = trace_v_q;
    trace_hartid_d  = trace_hartid_q;
    trace_pc_d      = trace_pc_q;
    trace_instr_d   = trace_instr_q;
    trace_itag_d    = trace_itag_q;
    trace_rd_w_v_d  = trace_rd_w_v_q;
    trace_rd_addr_d = trace_rd_addr_q;
    trace_rd_data_d = trace_rd_data_q;
    if (grant) begin
      trace_v_d       = 1'b1;
      trace_hartid_d  = winner;
      trace_pc_d      = pc_a[winner];
      trace_instr_d   = instr_a[winner];
      trace_itag_d    = itag_q[winner];
      trace_rd_w_v_d  = req_rd_w_v_i[winner];
      trace_rd_addr_d = addr_a[winner];
      trace_rd_data_d = data_a[winner];
      itag_d[winner]  = itag_q[winner] + itag_width_p'(1);
      ptr_d           = (winner == hid_width_lp'(num_req_p - 1)) ? '0 : winner + 1'b1;
    end else if (load) begin
      // Drained with nothing to replace it: data fields deliberately hold.
      trace_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_q           <= '0;
      for (int unsigned i = 0; i < nreq_lp; i++) itag_q[i] <= '0;
      trace_v_q       <= 1'b0;
      trace_hartid_q  <= '0;
      trace_pc_q      <= '0;
      trace_instr_q   <= '0;
      trace_itag_q    <= '0;
      trace_rd_w_v_q  <= 1'b0;
      trace_rd_addr_q <= '0;
      trace_rd_data_q <= '0;
    end else begin
      ptr_q           <= ptr_d;
      itag_q          <= itag_d;
      trace_v_q       <= trace_v_d;
      trace_hartid_q  <= trace_hartid_d;
      trace_pc_q      <= trace_pc_d;
      trace_instr_q   <= trace_instr_d;
      trace_itag_q    <= trace_itag_d;
      trace_rd_w_v_q  <= trace_rd_w_v_d;
      trace_rd_addr_q <= trace_rd_addr_d;
      trace_rd_data_q <= trace_rd_data_d;
    end
  end

  assign trace_v_o       = trace_v_q;
  assign trace_hartid_o  = trace_hartid_q;
  assign trace_pc_o      = trace_pc_q;
  assign trace_instr_o   = trace_instr_q;
  assign trace_itag_o    = trace_itag_q;
  assign trace_rd_w_v_o  = trace_rd_w_v_q;
  assign trace_rd_addr_o = trace_rd_addr_q;
  assign trace_rd_data_o = trace_rd_data_q;

endmodule

// File: tb/tb_bp_nonsynth_commit_trace_arbiter.sv
// Testbench for bp_nonsynth_commit_trace_arbiter: four cores, 2-bit retire
// tags so tag wrap-around is reachable. Expected outputs come from a
// record-level model of the arbitration rules.

module tb_bp_nonsynth_commit_trace_arbiter;

  localparam int N  = 4;
  localparam int VA = 39;
  localparam int IW = 32;
  localparam int DW = 64;
  localparam int TW = 2;
  localparam int HW = 2;
  localparam int OW = 1 + HW + VA + IW + TW + 1 + 5 + DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, en, ready;
  logic [N-1:0]  p_v;
  logic [VA-1:0] p_pc    [N];
  logic [IW-1:0] p_instr [N];
  logic [N-1:0]  p_wv;
  logic [4:0]    p_addr  [N];
  logic [DW-1:0] p_data  [N];

  logic [N*VA-1:0] req_pc;
  logic [N*IW-1:0] req_instr;
  logic [N*5-1:0]  req_addr;
  logic [N*DW-1:0] req_data;

  always_comb begin
    req_pc = '0; req_instr = '0; req_addr = '0; req_data = '0;
    for (int i = 0; i < N; i++) begin
      req_pc[i*VA +: VA]    = p_pc[i];
      req_instr[i*IW +: IW] = p_instr[i];
      req_addr[i*5 +: 5]    = p_addr[i];
      req_data[i*DW +: DW]  = p_data[i];
    end
  end

  logic [N-1:0]  req_yumi_o;
  logic          trace_v_o;
  logic [HW-1:0] trace_hartid_o;
  logic [VA-1:0] trace_pc_o;
  logic [IW-1:0] trace_instr_o;
  logic [TW-1:0] trace_itag_o;
  logic          trace_rd_w_v_o;
  logic [4:0]    trace_rd_addr_o;
  logic [DW-1:0] trace_rd_data_o;

  bp_nonsynth_commit_trace_arbiter #(
    .num_req_p(N), .vaddr_width_p(VA), .instr_width_p(IW),
    .dpath_width_p(DW), .itag_width_p(TW)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .en_i(en),
    .req_v_i(p_v), .req_pc_i(req_pc), .req_instr_i(req_instr),
    .req_rd_w_v_i(p_wv), .req_rd_addr_i(req_addr), .req_rd_data_i(req_data),
    .req_yumi_o(req_yumi_o), .trace_v_o(trace_v_o), .trace_hartid_o(trace_hartid_o),
    .trace_pc_o(trace_pc_o), .trace_instr_o(trace_instr_o), .trace_itag_o(trace_itag_o),
    .trace_rd_w_v_o(trace_rd_w_v_o), .trace_rd_addr_o(trace_rd_addr_o),
    .trace_rd_data_o(trace_rd_data_o), .trace_ready_i(ready)
  );

  logic [OW-1:0] dut_out;
  assign dut_out = {trace_v_o, trace_hartid_o, trace_pc_o, trace_instr_o, trace_itag_o,
                    trace_rd_w_v_o, trace_rd_addr_o, trace_rd_data_o};

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  typedef struct {
    int            hart;
    logic [VA-1:0] pc;
    logic [IW-1:0] instr;
    int            itag;
    logic          wv;
    logic [4:0]    addr;
    logic [DW-1:0] data;
  } rec_t;

  rec_t m_rec;
  bit   m_v;
  int   m_ptr;
  int   m_itag [N];

  task automatic model_reset();
    m_v = 0; m_ptr = 0;
    m_rec = '{hart: 0, pc: '0, instr: '0, itag: 0, wv: 1'b0, addr: '0, data: '0};
    for (int i = 0; i < N; i++) m_itag[i] = 0;
  endtask

  // Core that wins this cycle, or -1 when nothing is granted.
  function automatic int model_winner();
    if (!(!m_v || ready) || !en) return -1;
    for (int k = 0; k < N; k++)
      if (p_v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_yumi();
    int w = model_winner();
    return (w < 0) ? '0 : N'(1) << w;
  endfunction

  function automatic logic [OW-1:0] exp_out();
    return {m_v, HW'(m_rec.hart), m_rec.pc, m_rec.instr, TW'(m_rec.itag),
            m_rec.wv, m_rec.addr, m_rec.data};
  endfunction

  task automatic model_clock(input int w);
    if (w >= 0) begin
      m_rec = '{hart: w, pc: p_pc[w], instr: p_instr[w], itag: m_itag[w],
                wv: p_wv[w], addr: p_addr[w], data: p_data[w]};
      m_itag[w] = (m_itag[w] + 1) % (1 << TW);
      m_ptr = (w + 1) % N;
      m_v = 1;
    end else if (!m_v || ready) begin
      m_v = 0;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic new_rec(input int i);
    p_v[i]     = 1'b1;
    p_pc[i]    = VA'({$urandom(), $urandom()});
    p_instr[i] = $urandom();
    p_wv[i]    = 1'($urandom());
    p_addr[i]  = 5'($urandom());
    p_data[i]  = {$urandom(), $urandom()};
  endtask

  // Advance one clock; the model steps with the inputs the DUT samples.
  task automatic tick(output int w);
    w = model_winner();
    model_clock(w);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    #2;
    reset_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int w;
    en = 1'b1; ready = 1'b1;
    for (int i = 0; i < N; i++) new_rec(i);
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    model_reset();
    #2;
    n_checks++; if (dut_out !== exp_out()) $display("FAIL reset_out got=%h exp=%h", dut_out, exp_out()); else n_pass++;
    n_checks++; if (req_yumi_o !== 4'b0000) $display("FAIL reset_yumi got=%b exp=0000", req_yumi_o); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (req_yumi_o !== exp_yumi()) $display("FAIL reset_run_yumi got=%b exp=%b", req_yumi_o, exp_yumi()); else n_pass++;
      tick(w);
      if (w >= 0) new_rec(w);
      n_checks++; if (dut_out !== exp_out()) $display("FAIL reset_run_out got=%h exp=%h", dut_out, exp_out()); else n_pass++;
    end
    // Mid-stream asynchronous reset with a valid record held
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (trace_v_o !== 1'b0) $display("FAIL reset_async_v got=%b exp=0", trace_v_o); else n_pass++;
    n_checks++; if (dut_out !== exp_out()) $display("FAIL reset_async_out got=%h exp=%h", dut_out, exp_out()); else n_pass++;
    #1 reset_n = 1'b1;
    #1;
    n_checks++; if (req_yumi_o !== 4'b0001) $display("FAIL reset_regrant_yumi got=%b exp=0001", req_yumi_o); else n_pass++;
    tick(w);
    if (w >= 0) new_rec(w);
    n_checks++; if ({trace_v_o, trace_hartid_o, trace_itag_o} !== {1'b1, 2'd0, 2'd0})
      $display("FAIL reset_regrant got v/hart/itag=%b/%0d/%0d exp=1/0/0", trace_v_o, trace_hartid_o, trace_itag_o); else n_pass++;
    n_checks++; if (dut_out !== exp_out()) $display("FAIL reset_regrant_out got=%h exp=%h", dut_out, exp_out()); else n_pass++;
  endtask

  task automatic test_fairness();
    int w;
    do_reset();
    for (int i = 0; i < N; i++) new_rec(i);
    en = 1'b1; ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_checks++; if (req_yumi_o !== exp_yumi()) $display("FAIL fair_yumi got=%b exp=%b", req_yumi_o, exp_yumi()); else n_pass++;
      tick(w);
      if (w >= 0) new_rec(w);
      n_checks++; if ({trace_hartid_o, trace_itag_o} !== {HW'(k % 4), TW'(k / 4)})
        $display("FAIL fair_seq[%0d] got hart/itag=%0d/%0d exp=%0d/%0d", k, trace_hartid_o, trace_itag_o, k % 4, k / 4); else n_pass++;
      n_checks++; if (dut_out !== exp_out()) $display("FAIL fair_out got=%h exp=%h", dut_out, exp_out()); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int w;
    do_reset();
    p_v = '0; en = 1'b1; ready = 1'b1;
    new_rec(1);
    p_pc[1] = 39'h0_8000_0000;
    #1;
    n_checks++; if (req_yumi_o !== 4'b0010) $display("FAIL bp_first_yumi got=%b exp=0010", req_yumi_o); else n_pass++;
    tick(w);
    p_v[1] = 1'b0;
    new_rec(2);
    ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++; if (req_yumi_o !== 4'b0000) $display("FAIL bp_hold_yumi got=%b exp=0000", req_yumi_o); else n_pass++;
      tick(w);
      n_checks++; if (dut_out !== exp_out()) $display("FAIL bp_hold_out got=%h exp=%h", dut_out, exp_out()); else n_pass++;
      n_checks++; if ({trace_v_o, trace_pc_o, trace_itag_o} !== {1'b1, 39'h0_8000_0000, 2'd0})
        $display("FAIL bp_hold_pc got v/pc/itag=%b/%h/%0d exp=1/0080000000/0", trace_v_o, trace_pc_o, trace_itag_o); else n_pass++;
    end
    ready = 1'b1;
    #1;
    n_checks++; if (req_yumi_o !== 4'b0100) $display("FAIL bp_release_yumi got=%b exp=0100", req_yumi_o); else n_pass++;
    tick(w);
    p_v[2] = 1'b0;
    n_checks++; if ({trace_v_o, trace_hartid_o, trace_itag_o} !== {1'b1, 2'd2, 2'd0})
      $display("FAIL bp_release got v/hart/itag=%b/%0d/%0d exp=1/2/0", trace_v_o, trace_hartid_o, trace_itag_o); else n_pass++;
    n_checks++; if (dut_out !== exp_out()) $display("FAIL bp_release_out got=%h exp=%h", dut_out, exp_out()); else n_pass++;
    new_rec(1);
    #1;
    tick(w);
    p_v[1] = 1'b0;
    n_checks++; if ({trace_hartid_o, trace_itag_o} !== {2'd1, 2'd1})
      $display("FAIL bp_core1_tag got hart/itag=%0d/%0d exp=1/1", trace_hartid_o, trace_itag_o); else n_pass++;
  endtask

  task automatic test_wrap();
    int w;
    int exp_tags [5] = '{0, 1, 2, 3, 0};
    do_reset();
    p_v = '0; en = 1'b1; ready = 1'b1;
    new_rec(2);
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++; if (req_yumi_o !== 4'b0100) $display("FAIL wrap_yumi got=%b exp=0100", req_yumi_o); else n_pass++;
      tick(w);
      new_rec(2);
      n_checks++; if ({trace_hartid_o, trace_itag_o} !== {2'd2, TW'(exp_tags[k])})
        $display("FAIL wrap_tag[%0d] got hart/itag=%0d/%0d exp=2/%0d", k, trace_hartid_o, trace_itag_o, exp_tags[k]); else n_pass++;
      n_checks++; if (dut_out !== exp_out()) $display("FAIL wrap_out got=%h exp=%h", dut_out, exp_out()); else n_pass++;
    end
    p_v = '0;
  endtask

  task automatic test_en();
    int w;
    do_reset();
    for (int i = 0; i < N; i++) new_rec(i);
    en = 1'b1; ready = 1'b1;
    #1;
    n_checks++; if (req_yumi_o !== 4'b0001) $display("FAIL en_first_yumi got=%b exp=0001", req_yumi_o); else n_pass++;
    tick(w);
    new_rec(0);
    en = 1'b0; ready = 1'b0;
    #1;
    n_checks++; if (req_yumi_o !== 4'b0000) $display("FAIL en_off_hold_yumi got=%b exp=0000", req_yumi_o); else n_pass++;
    tick(w);
    n_checks++; if (dut_out !== exp_out()) $display("FAIL en_off_hold_out got=%h exp=%h", dut_out, exp_out()); else n_pass++;
    ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (req_yumi_o !== 4'b0000) $display("FAIL en_off_yumi got=%b exp=0000", req_yumi_o); else n_pass++;
      tick(w);
      n_checks++; if (trace_v_o !== 1'b0) $display("FAIL en_off_drain got v=%b exp=0", trace_v_o); else n_pass++;
      n_checks++; if (dut_out !== exp_out()) $display("FAIL en_off_out got=%h exp=%h", dut_out, exp_out()); else n_pass++;
    end
    en = 1'b1;
    #1;
    n_checks++; if (req_yumi_o !== 4'b0010) $display("FAIL en_on_yumi got=%b exp=0010", req_yumi_o); else n_pass++;
    tick(w);
    new_rec(1);
    n_checks++; if ({trace_v_o, trace_hartid_o, trace_itag_o} !== {1'b1, 2'd1, 2'd0})
      $display("FAIL en_on got v/hart/itag=%b/%0d/%0d exp=1/1/0", trace_v_o, trace_hartid_o, trace_itag_o); else n_pass++;
  endtask

  task automatic test_sparse();
    int w;
    do_reset();
    p_v = '0; en = 1'b1; ready = 1'b1;
    new_rec(3);
    #1;
    n_checks++; if (req_yumi_o !== 4'b1000) $display("FAIL sparse_yumi got=%b exp=1000", req_yumi_o); else n_pass++;
    tick(w);
    p_v[3] = 1'b0;
    n_checks++; if ({trace_v_o, trace_hartid_o, trace_itag_o} !== {1'b1, 2'd3, 2'd0})
      $display("FAIL sparse_rec got v/hart/itag=%b/%0d/%0d exp=1/3/0", trace_v_o, trace_hartid_o, trace_itag_o); else n_pass++;
    new_rec(0); new_rec(3);
    #1;
    n_checks++; if (req_yumi_o !== 4'b0001) $display("FAIL sparse_ptr_wrap got=%b exp=0001", req_yumi_o); else n_pass++;
    tick(w);
    p_v[0] = 1'b0;
    n_checks++; if (dut_out !== exp_out()) $display("FAIL sparse_out got=%h exp=%h", dut_out, exp_out()); else n_pass++;
    p_v = '0;
  endtask

  task automatic test_random();
    int w;
    do_reset();
    p_v = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!p_v[i] && ($urandom_range(2) == 0)) new_rec(i);
      en    = ($urandom_range(7) != 0);
      ready = ($urandom_range(3) != 0);
      #1;
      n_checks++; if (req_yumi_o !== exp_yumi()) $display("FAIL rand_yumi[%0d] got=%b exp=%b", c, req_yumi_o, exp_yumi()); else n_pass++;
      tick(w);
      if (w >= 0) p_v[w] = 1'b0;
      n_checks++; if (dut_out !== exp_out()) $display("FAIL rand_out[%0d] got=%h exp=%h", c, dut_out, exp_out()); else n_pass++;
    end
  endtask

  initial begin
    p_v = '0; en = 1'b0; ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      p_pc[i] = '0; p_instr[i] = '0; p_addr[i] = '0; p_data[i] = '0;
    end
    p_wv = '0;
    model_reset();
    test_reset();
    test_fairness();
    test_backpressure();
    test_wrap();
    test_en();
    test_sparse();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
